// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port (AR/R) among N_REQ cache-side requesters.
// One burst in flight at a time; length and response errors are reported as sticky flags.
module axi_rd_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [N_REQ*AW-1:0] req_araddr,
  input  logic [N_REQ*8-1:0]  req_arlen,
  input  logic [N_REQ*3-1:0]  req_arsize,
  input  logic [N_REQ-1:0]    req_arvalid,
  output logic [N_REQ-1:0]    req_arready,
  output logic [DW-1:0]       req_rdata,
  output logic [1:0]          req_rresp,
  output logic                req_rlast,
  output logic [N_REQ-1:0]    req_rvalid,
  input  logic [N_REQ-1:0]    req_rready,
  output logic [3:0]          m_arid,
  output logic [AW-1:0]       m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [3:0]          m_rid,
  input  logic [DW-1:0]       m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                len_err,
  output logic                resp_err
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid is never withdrawn by this block once raised, and ready may be held or dropped freely.
  localparam int PW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, grant, pick, idx;
  logic            pick_vld;
  logic [AW-1:0]   addr_q, sel_addr;
  logic [7:0]      len_q, sel_len;
  logic [2:0]      size_q, sel_size;
  logic [8:0]      beat_cnt;
  logic            ar_hs, r_hs;

  // Scan from ptr upward; iterating from the far end lets the nearest valid index win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req_arvalid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == pick) begin
        sel_addr = req_araddr[i*AW +: AW];
        sel_len  = req_arlen[i*8 +: 8];
        sel_size = req_arsize[i*3 +: 3];
      end
    end
  end

  assign ar_hs = (state == S_AR) && m_arready;
  assign r_hs  = (state == S_R) && m_rvalid && m_rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_AR;
      S_AR:    if (ar_hs) state_nxt = S_R;
      S_R:     if (r_hs && m_rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state)
      S_IDLE:  if (pick_vld && aresetn) req_arready[pick] = 1'b1;
      S_AR:    m_arvalid = 1'b1;
      S_R: begin
        m_rready          = req_rready[grant];
        req_rvalid[grant] = m_rvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr      <= '0;
      grant    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_vld) begin
        grant  <= pick;
        addr_q <= sel_addr;
        len_q  <= sel_len;
        size_q <= sel_size;
      end
      if (ar_hs) beat_cnt <= '0;
      if (r_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (m_rlast) ptr <= (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        // beat_cnt counts beats already accepted, so the last beat arrives at beat_cnt == arlen.
        if (m_rlast ? (beat_cnt != {1'b0, len_q}) : (beat_cnt >= {1'b0, len_q}))
          len_err <= 1'b1;
        if ((m_rresp != 2'b00) || (m_rid != 4'(grant)))
          resp_err <= 1'b1;
      end
    end
  end

  assign m_arid    = 4'(grant);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = 2'b01;
  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

- Round-robin read-channel arbiter that shares the single AXI read port (AR/R) among up to `N_REQ` cache-side requesters.
- Typical requesters: instruction cache line fill, data cache line fill, uncached data read.
- Owns one burst at a time: grants a requester, issues its AR, routes R beats back to it, then releases.
- Sits between the cache refill engines and the top-level AXI master pins; reports length and response errors as sticky flags.

## Interface

Parameters:
- `N_REQ`, default 3: number of requesters (2..4); requester index is also the AXI ID.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `aclk`  in  1: clock. One clock domain, all logic on rising edge.
- `aresetn`  in  1: reset, asynchronous, active-low.
- `req_araddr`  in  N_REQ*AW: per-requester burst address, requester i in slice [i*AW +: AW].
- `req_arlen`  in  N_REQ*8: per-requester AXI length (beats-1).
- `req_arsize`  in  N_REQ*3: per-requester AXI size.
- `req_arvalid`  in  N_REQ: request valid, held until accepted.
- `req_arready`  out  N_REQ: one-hot accept pulse.
- `req_rdata`  out  DW: shared read data (valid only with the owner's rvalid).
- `req_rresp`  out  2: shared response.
- `req_rlast`  out  1: shared last flag.
- `req_rvalid`  out  N_REQ: per-requester beat valid.
- `req_rready`  in  N_REQ: per-requester beat ready.
- `m_arid`  out  4: AR ID.
- `m_araddr`  out  AW: AR address.
- `m_arlen`  out  8: AR length.
- `m_arsize`  out  3: AR size.
- `m_arburst`  out  2: AR burst type.
- `m_arvalid`  out  1: AR valid.
- `m_arready`  in  1: AR ready.
- `m_rid`  in  4: R ID.
- `m_rdata`  in  DW: R data.
- `m_rresp`  in  2: R response.
- `m_rlast`  in  1: R last.
- `m_rvalid`  in  1: R valid.
- `m_rready`  out  1: R ready.
- `len_err`  out  1: sticky burst-length mismatch flag.
- `resp_err`  out  1: sticky non-OKAY rresp flag.

## Operation

States:
- **IDLE**
  - Scan `req_arvalid` starting at `ptr`, then ptr+1, …, wrapping modulo `N_REQ`.
  - First valid requester g wins: `req_arready[g]` = 1 combinationally this cycle.
  - Latch g's addr/len/size and `grant` = g; go to AR.
  - No valid request: stay in IDLE.
- **AR**
  - `m_arvalid` = 1 from registers; `m_arid` = grant zero-extended; `m_arburst` = 2'b01 (INCR).
  - Registers are stable until `m_arvalid && m_arready`; then clear beat counter and go to R.
- **R**
  - `req_rvalid[grant]` = `m_rvalid`; other bits 0.
  - `m_rready` = `req_rready[grant]`.
  - `req_rdata`/`req_rresp`/`req_rlast` pass through from `m_*`.
  - On every handshake (`m_rvalid && m_rready`): beat counter +1.
  - On handshake with `m_rlast`: `ptr` = grant+1 (wraps to 0 at `N_REQ`); go to IDLE.

Flags:
- `len_err` sets if `m_rlast` arrives with beat count != latched arlen, or if a handshake without rlast occurs after count == arlen. The burst still ends only on rlast.
- `resp_err` sets on any handshake with `m_rresp` != 0.
- `m_rid` is not used for routing. A handshake with `m_rid` != grant sets `resp_err`.
- Both flags clear only on reset.

Boundaries:
- A requester that drops `req_arvalid` without being accepted is ignored; no state change.
- Simultaneous requests: exactly one is granted; the others keep waiting, and the round-robin rotation guarantees each is granted within `N_REQ` bursts.
- `m_rvalid` in IDLE or AR is not accepted (`m_rready` = 0).

## Timing

- Reset values: state IDLE, `ptr` = 0, `grant` = 0, all `req_arready`/`req_rvalid` = 0, `m_arvalid` = 0, `m_rready` = 0, `m_araddr`/`m_arlen`/`m_arsize` = 0, `m_arid` = 0, `m_arburst` = 2'b01, both flags 0.
- Reset asserted mid-burst: immediate return to reset values; the in-flight burst is abandoned.
- Latency:
  - Request accepted in its first IDLE cycle.
  - `m_arvalid` rises the next cycle.
  - R path adds zero latency (combinational).
- One IDLE cycle between the last beat and the next grant.
- Peak occupancy: 2 + (arlen+1) cycles per burst with no backpressure.

## Test plan

- **Single burst.** Req1 araddr=0x1FC0_0000, arlen=7, `m_arready` immediate.
  - `req_arready[1]` pulses at cycle 0; AR at cycle 1 with arid=1.
  - 8 beats reach `req_rvalid[1]` only; IDLE after rlast; no flags.
- **Simultaneous requests.** All three assert arvalid together and re-request after each grant.
  - Grant order 0,1,2,0,1,2.
- **AR backpressure.** `m_arready` low for 5 cycles.
  - `m_araddr`/`m_arlen` held stable; no second grant.
- **R backpressure.** `req_rready[grant]` low for 3 cycles mid-burst.
  - `m_rready` low for those cycles; beat count unchanged; burst still completes.
- **Errors.** arlen=3 with rlast on beat 2 → `len_err`=1. Beat with rresp=2'b10 → `resp_err`=1. Both stay set.
- **Reset mid-burst.** `aresetn` low during R.
  - All outputs return to reset values in the same cycle; a fresh request after release is granted to requester 0 first.
